// File: rtl/cache_line_mem_adapter.sv
// cache_line_mem_adapter: splits line refill/write-back requests into single-beat memory transactions.
// Define CACHE_CRITICAL_WORD_FIRST_EN to start reads at the requested beat and wrap around the line.
module cache_line_mem_adapter #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int LINE_WIDTH = 128,
   parameter int BUS_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ADDRESS_WIDTH-1:0]  req_address,
   input  logic [LINE_WIDTH-1:0]     req_data,
   input  logic [LINE_WIDTH/8-1:0]   req_strobe,
   input  logic                      req_wen,
   output logic                      rsp_valid,
   output logic [LINE_WIDTH-1:0]     rsp_data,
   output logic                      mem_req_valid,
   output logic [ADDRESS_WIDTH-1:0]  mem_req_address,
   output logic [BUS_WIDTH-1:0]      mem_req_data,
   output logic [BUS_WIDTH/8-1:0]    mem_req_strobe,
   output logic                      mem_req_wen,
   input  logic                      mem_rsp_valid,
   input  logic [BUS_WIDTH-1:0]      mem_rsp_data,
   output logic                      err_unexpected_rsp
);
   localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
   localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
   localparam int BOFF = $clog2(BUS_WIDTH / 8);
   localparam logic [CW-1:0] MASK = CW'(BEATS - 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state, state_nx;
   logic run;
   logic [ADDRESS_WIDTH-1:0] base, beat_addr;
   logic [LINE_WIDTH-1:0] line;
   logic [LINE_WIDTH/8-1:0] strb;
   logic wen;
   logic [CW-1:0] beat, start, start_req, beat_inc;
   logic [BUS_WIDTH/8-1:0] beat_strb;
   logic accept, skip, last, advance;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
   assign start_req = req_wen ? '0 : CW'(req_address >> BOFF) & MASK;
`else
   assign start_req = '0;
`endif
   assign accept = req_ready && req_valid;
   assign beat_strb = strb[beat*(BUS_WIDTH/8) +: BUS_WIDTH/8];
   assign skip = wen && beat_strb == '0;
   assign beat_inc = (beat + CW'(1)) & MASK;
   // the last beat is the one just before the start beat, modulo BEATS
   assign last = beat_inc == start;
   assign advance = (state == ISSUE && skip) || (state == WAIT && mem_rsp_valid);
   assign beat_addr = base + (ADDRESS_WIDTH'(beat) << BOFF);
   assign req_ready = run && state == IDLE;
   assign rsp_valid = state == DONE;
   assign rsp_data = (state == DONE && !wen) ? line : '0;
   assign mem_req_valid = state == ISSUE && !skip;
   assign mem_req_address = mem_req_valid ? beat_addr : '0;
   assign mem_req_data = mem_req_valid ? line[beat*BUS_WIDTH +: BUS_WIDTH] : '0;
   assign mem_req_strobe = mem_req_valid ? beat_strb : '0;
   assign mem_req_wen = mem_req_valid && wen;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? ISSUE : IDLE;
         ISSUE:   state_nx = skip ? (last ? DONE : ISSUE) : WAIT;
         WAIT:    state_nx = mem_rsp_valid ? (last ? DONE : ISSUE) : WAIT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         run <= 1'b0;
      end else begin
         state <= state_nx;
         run <= 1'b1;
      end
   end
   // read beats overwrite their own slot of the latched line, which then becomes the refill buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base <= '0;
         line <= '0;
         strb <= '0;
         wen <= 1'b0;
         beat <= '0;
         start <= '0;
         err_unexpected_rsp <= 1'b0;
      end else begin
         if (accept) begin
            base <= req_address & ~ADDRESS_WIDTH'(LINE_WIDTH / 8 - 1);
            line <= req_data;
            strb <= req_strobe;
            wen <= req_wen;
            beat <= start_req;
            start <= start_req;
         end
         if (advance) beat <= beat_inc;
         if (state == WAIT && mem_rsp_valid && !wen) line[beat*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data;
         if (mem_rsp_valid && state != WAIT) err_unexpected_rsp <= 1'b1;
      end
   end
endmodule
